// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_ctrl
// Brief    : MEM-stage data-memory sequencer. Accepts one load/store at a
//            time, checks alignment, drives a variable-latency memory with
//            lane byte-enables, times out stalled accesses, extends load
//            data and returns it over a valid/ready response port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [1:0]  resp_err
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic [1:0] c_ERR_OK    = 2'b00;
    localparam logic [1:0] c_ERR_ALIGN = 2'b01;
    localparam logic [1:0] c_ERR_TOUT  = 2'b10;

    // Last counter value of an access before it is declared timed out.
    localparam logic [CNT_W-1:0] c_TO_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit               c_TO_EN   = (TIMEOUT != 0);

    logic [1:0]       r_state, w_next_state;
    logic [CNT_W-1:0] r_cnt;

    // Request fields needed after acceptance for load-data extraction.
    logic             r_lat_we;
    logic [1:0]       r_lat_size;
    logic             r_lat_signed;
    logic [1:0]       r_lat_lo;

    logic             r_req_ready,  w_req_ready_d;
    logic             r_mem_en,     w_mem_en_d;
    logic             r_mem_we,     w_mem_we_d;
    logic [3:0]       r_mem_be,     w_mem_be_d;
    logic [31:0]      r_mem_addr,   w_mem_addr_d;
    logic [31:0]      r_mem_wdata,  w_mem_wdata_d;
    logic             r_resp_valid, w_resp_valid_d;
    logic [31:0]      r_resp_rdata, w_resp_rdata_d;
    logic [1:0]       r_resp_err,   w_resp_err_d;

    logic             w_accept;
    logic             w_illegal;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_shift;
    logic [31:0]      w_load_data;

    assign w_accept  = (r_state == c_IDLE) && r_req_ready && req_valid;
    assign w_timeout = c_TO_EN && (r_cnt == c_TO_LAST);

    // Alignment / size legality of the incoming request.
    always_comb begin
        w_illegal = 1'b0;
        case (req_size)
            2'b00:   w_illegal = 1'b1;
            2'b10:   w_illegal = req_addr[0];
            2'b11:   w_illegal = |req_addr[1:0];
            default: w_illegal = 1'b0;
        endcase
    end

    // Lane byte-enables and replicated store data for the incoming request.
    always_comb begin
        w_be    = 4'b0000;
        w_wdata = req_wdata;
        case (req_size)
            2'b01: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b10: begin
                w_be    = req_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{req_wdata[15:0]}};
            end
            2'b11: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
            default: begin
                w_be    = 4'b0000;
                w_wdata = req_wdata;
            end
        endcase
    end

    // Select the addressed field of the read word and zero/sign-extend it.
    always_comb begin
        w_shift     = mem_rdata >> {r_lat_lo, 3'b000};
        w_load_data = mem_rdata;
        case (r_lat_size)
            2'b01:   w_load_data = {{24{r_lat_signed & w_shift[7]}}, w_shift[7:0]};
            2'b10:   w_load_data = r_lat_lo[1]
                                 ? {{16{r_lat_signed & mem_rdata[31]}}, mem_rdata[31:16]}
                                 : {{16{r_lat_signed & mem_rdata[15]}}, mem_rdata[15:0]};
            default: w_load_data = mem_rdata;
        endcase
    end

    // Next-state decision.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_illegal ? c_RESP : c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (mem_ack || w_timeout) begin
                    w_next_state = c_RESP;
                end
            end
            c_RESP: begin
                if (resp_ready) begin
                    w_next_state = c_IDLE;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // Next values of the registered outputs; each holds unless changed here.
    always_comb begin
        w_req_ready_d  = r_req_ready;
        w_mem_en_d     = r_mem_en;
        w_mem_we_d     = r_mem_we;
        w_mem_be_d     = r_mem_be;
        w_mem_addr_d   = r_mem_addr;
        w_mem_wdata_d  = r_mem_wdata;
        w_resp_valid_d = r_resp_valid;
        w_resp_rdata_d = r_resp_rdata;
        w_resp_err_d   = r_resp_err;
        case (r_state)
            c_IDLE: begin
                w_req_ready_d = 1'b1;
                if (w_accept) begin
                    w_req_ready_d = 1'b0;
                    if (w_illegal) begin
                        w_resp_valid_d = 1'b1;
                        w_resp_rdata_d = '0;
                        w_resp_err_d   = c_ERR_ALIGN;
                    end else begin
                        w_mem_en_d    = 1'b1;
                        w_mem_we_d    = req_we;
                        w_mem_be_d    = w_be;
                        w_mem_addr_d  = {req_addr[31:2], 2'b00};
                        w_mem_wdata_d = w_wdata;
                    end
                end
            end
            c_ACCESS: begin
                if (mem_ack || w_timeout) begin
                    w_mem_en_d     = 1'b0;
                    w_mem_we_d     = 1'b0;
                    w_mem_be_d     = 4'b0000;
                    w_resp_valid_d = 1'b1;
                    if (mem_ack) begin
                        w_resp_rdata_d = r_lat_we ? '0 : w_load_data;
                        w_resp_err_d   = c_ERR_OK;
                    end else begin
                        w_resp_rdata_d = '0;
                        w_resp_err_d   = c_ERR_TOUT;
                    end
                end
            end
            c_RESP: begin
                if (resp_ready) begin
                    w_resp_valid_d = 1'b0;
                    w_resp_rdata_d = '0;
                    w_resp_err_d   = c_ERR_OK;
                    w_req_ready_d  = 1'b1;
                end
            end
            default: begin
                w_req_ready_d = 1'b0;
            end
        endcase
    end

    // State, timeout counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_cnt        <= '0;
            r_req_ready  <= 1'b0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_be     <= 4'b0000;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= c_ERR_OK;
        end else begin
            r_state      <= w_next_state;
            r_cnt        <= (r_state == c_ACCESS) ? r_cnt + 1'b1 : '0;
            r_req_ready  <= w_req_ready_d;
            r_mem_en     <= w_mem_en_d;
            r_mem_we     <= w_mem_we_d;
            r_mem_be     <= w_mem_be_d;
            r_mem_addr   <= w_mem_addr_d;
            r_mem_wdata  <= w_mem_wdata_d;
            r_resp_valid <= w_resp_valid_d;
            r_resp_rdata <= w_resp_rdata_d;
            r_resp_err   <= w_resp_err_d;
        end
    end

    // Capture the request fields used to shape the load result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lat_we     <= 1'b0;
            r_lat_size   <= 2'b00;
            r_lat_signed <= 1'b0;
            r_lat_lo     <= 2'b00;
        end else if (w_accept) begin
            r_lat_we     <= req_we;
            r_lat_size   <= req_size;
            r_lat_signed <= req_signed;
            r_lat_lo     <= req_addr[1:0];
        end
    end

    assign req_ready  = r_req_ready;
    assign mem_en     = r_mem_en;
    assign mem_we     = r_mem_we;
    assign mem_be     = r_mem_be;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_ctrl
// Brief    : Self-checking bench for mem_access_ctrl: table of directed
//            load/store vectors plus timeout, backpressure and reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        mem_en;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [1:0]  resp_err;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ack_cyc;   // 0: request must be rejected without a memory access
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] rrdata;
        logic [1:0]  err;
    } vec_t;

    vec_t vecs[12];

    mem_access_ctrl #(
        .TIMEOUT (16),
        .CNT_W   (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_req_ready"},  {31'd0, req_ready},  32'd0);
        chk({tag, "_mem_en"},     {31'd0, mem_en},     32'd0);
        chk({tag, "_mem_we"},     {31'd0, mem_we},     32'd0);
        chk({tag, "_mem_be"},     {28'd0, mem_be},     32'd0);
        chk({tag, "_mem_addr"},   mem_addr,            32'd0);
        chk({tag, "_mem_wdata"},  mem_wdata,           32'd0);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_rdata"}, resp_rdata,          32'd0);
        chk({tag, "_resp_err"},   {30'd0, resp_err},   32'd0);
    endtask

    // Called at a negedge: present the request and let the next posedge accept it.
    task automatic send_req(input logic we, input logic [1:0] size, input logic sgn,
                            input logic [31:0] addr, input logic [31:0] wdata);
        req_we     = we;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int          resp_cyc = 0;
        int          en_cnt   = 0;
        logic        got_mem  = 1'b0;
        logic        stable   = 1'b1;
        logic        c_we     = 1'b0;
        logic [3:0]  c_be     = '0;
        logic [31:0] c_addr   = '0;
        logic [31:0] c_wdata  = '0;
        logic [31:0] r_data   = '0;
        logic [1:0]  r_err    = '0;
        int          exp_resp;
        string       t;
        t = $sformatf("v%0d", idx);
        wait_ready(t);
        send_req(v.we, v.size, v.sgn, v.addr, v.wdata);
        for (int c = 1; c <= 40 && resp_cyc == 0; c++) begin
            @(negedge clk);
            if (c == 1) chk({t, "_busy"}, {31'd0, req_ready}, 32'd0);
            if (mem_en === 1'b1) begin
                en_cnt++;
                if (!got_mem) begin
                    got_mem = 1'b1;
                    c_we = mem_we; c_be = mem_be; c_addr = mem_addr; c_wdata = mem_wdata;
                end else if (mem_we !== c_we || mem_be !== c_be ||
                             mem_addr !== c_addr || mem_wdata !== c_wdata) begin
                    stable = 1'b0;
                end
            end
            if (resp_valid === 1'b1) begin
                resp_cyc = c;
                r_data   = resp_rdata;
                r_err    = resp_err;
            end
            mem_rdata = v.rdata;
            mem_ack   = (v.ack_cyc != 0) && (c == v.ack_cyc);
        end
        mem_ack  = 1'b0;
        exp_resp = (v.ack_cyc == 0) ? 1 : v.ack_cyc + 1;
        chk({t, "_resp_cycle"}, resp_cyc, exp_resp);
        chk({t, "_mem_en_cycles"}, en_cnt, v.ack_cyc);
        chk({t, "_resp_rdata"}, r_data, v.rrdata);
        chk({t, "_resp_err"}, {30'd0, r_err}, {30'd0, v.err});
        if (v.ack_cyc != 0) begin
            chk({t, "_mem_we"}, {31'd0, c_we}, {31'd0, v.we});
            chk({t, "_mem_be"}, {28'd0, c_be}, {28'd0, v.be});
            chk({t, "_mem_addr"}, c_addr, {v.addr[31:2], 2'b00});
            chk({t, "_mem_wdata"}, c_wdata, v.mwdata);
            chk({t, "_mem_stable"}, {31'd0, stable}, 32'd1);
        end
        // resp_ready is high, so the handshake happens on this edge.
        @(posedge clk);
        @(negedge clk);
        chk({t, "_resp_cleared"}, {31'd0, resp_valid}, 32'd0);
        chk({t, "_ready_back"}, {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        int   en_cnt;
        int   resp_cyc;
        logic flag;

        //        we  size   sgn addr        wdata         rdata         ack be       mwdata        rrdata        err
        vecs[0]  = '{1'b0, 2'b01, 1'b1, 32'h103, 32'h0,        32'h80112233, 1, 4'b1000, 32'h0,        32'hFFFFFF80, 2'b00};
        vecs[1]  = '{1'b0, 2'b10, 1'b0, 32'h102, 32'h0,        32'hBEEF1234, 1, 4'b1100, 32'h0,        32'h0000BEEF, 2'b00};
        vecs[2]  = '{1'b1, 2'b01, 1'b0, 32'h201, 32'h000000A5, 32'hFFFFFFFF, 3, 4'b0010, 32'hA5A5A5A5, 32'h0,        2'b00};
        vecs[3]  = '{1'b0, 2'b11, 1'b0, 32'h302, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b01};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 32'h400, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b01};
        vecs[5]  = '{1'b0, 2'b10, 1'b1, 32'h100, 32'h0,        32'h12348001, 1, 4'b0011, 32'h0,        32'hFFFF8001, 2'b00};
        vecs[6]  = '{1'b0, 2'b11, 1'b1, 32'h500, 32'h0,        32'hDEADBEEF, 2, 4'b1111, 32'h0,        32'hDEADBEEF, 2'b00};
        vecs[7]  = '{1'b1, 2'b10, 1'b0, 32'h602, 32'h1234ABCD, 32'h0,        1, 4'b1100, 32'hABCDABCD, 32'h0,        2'b00};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h700, 32'h0,        32'h000000F0, 1, 4'b0001, 32'h0,        32'h000000F0, 2'b00};
        vecs[9]  = '{1'b0, 2'b01, 1'b1, 32'h701, 32'h0,        32'h00007F00, 1, 4'b0010, 32'h0,        32'h0000007F, 2'b00};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 32'h801, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        32'h0,        2'b01};
        vecs[11] = '{1'b1, 2'b11, 1'b0, 32'h900, 32'hCAFEF00D, 32'h0,        2, 4'b1111, 32'hCAFEF00D, 32'h0,        2'b00};

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_size   = 2'b00;
        req_signed = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        mem_rdata  = '0;
        mem_ack    = 1'b0;
        resp_ready = 1'b1;

        // Reset state and first-edge req_ready rise.
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;
        #1 chk("ready_before_edge", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        chk("ready_after_release", {31'd0, req_ready}, 32'd1);

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            run_vec(i, vecs[i]);
        end

        // Timeout: no ack; a late ack on cycle 20 must be ignored.
        wait_ready("to");
        resp_ready = 1'b0;
        send_req(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0);
        en_cnt   = 0;
        resp_cyc = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (mem_en === 1'b1) en_cnt++;
            if (resp_valid === 1'b1 && resp_cyc == 0) resp_cyc = c;
            mem_rdata = 32'h12345678;
            mem_ack   = (c == 20);
        end
        mem_ack = 1'b0;
        chk("to_mem_en_cycles", en_cnt, 16);
        chk("to_resp_cycle", resp_cyc, 17);
        chk("to_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("to_resp_err", {30'd0, resp_err}, 32'd2);
        chk("to_resp_rdata", resp_rdata, 32'd0);
        chk("to_mem_en_after", {31'd0, mem_en}, 32'd0);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("to_ready_back", {31'd0, req_ready}, 32'd1);

        // Backpressure: response held stable while resp_ready is low.
        resp_ready = 1'b0;
        send_req(1'b0, 2'b11, 1'b0, 32'h2000, 32'h0);
        @(negedge clk);
        chk("bp_mem_en", {31'd0, mem_en}, 32'd1);
        mem_rdata = 32'h11223344;
        mem_ack   = 1'b1;
        @(negedge clk);
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp_resp_rdata", resp_rdata, 32'h11223344);
        flag = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== 32'h11223344 || resp_err !== 2'b00 ||
                req_ready !== 1'b0 || mem_en !== 1'b0) flag = 1'b0;
        end
        chk("bp_stable", {31'd0, flag}, 32'd1);
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_ready_back", {31'd0, req_ready}, 32'd1);

        // Reset in the middle of an access.
        send_req(1'b1, 2'b11, 1'b0, 32'h3000, 32'h00000055);
        @(negedge clk);
        @(negedge clk);
        chk("rst_pre_mem_en", {31'd0, mem_en}, 32'd1);
        #2 rst = 1'b1;
        #1 chk_reset_vals("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", {31'd0, req_ready}, 32'd1);
        flag = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || mem_en !== 1'b0) flag = 1'b0;
        end
        chk("rst_no_response", {31'd0, flag}, 32'd1);

        // Controller is usable again after reset.
        run_vec(100, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
